// File: rtl/aes_tv_pkg.sv
// -----------------------------------------------------------------------------
// aes_tv_pkg
//   Shared constants and types for the AES test-vector source.
//   Contents:
//     TV_ENTRY0..3  known-answer table entries (128-bit, truncated by the user
//                   to the instance's DATA_W)
//     MODE_*        burst mode encodings carried on the 'mode' input
//     tv_state_e    FSM state type (IDLE, RUN)
//     TV_LFSR_TAPS  default Galois feedback mask, x^128 + x^7 + x^2 + x + 1
//     tv_entry()    table lookup by integer index; indices past 3 return 0
// -----------------------------------------------------------------------------
package aes_tv_pkg;

    localparam logic [127:0] TV_ENTRY0 = 128'h58cf0bfc4d7c72d958cf0bfc4d7c72d9;
    localparam logic [127:0] TV_ENTRY1 = 128'hafffffffffffffffffffffffffffffff;
    localparam logic [127:0] TV_ENTRY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] TV_ENTRY3 = 128'h3243f6a8885a308d313198a2e0370734;

    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_SEQ   = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;

    localparam logic [127:0] TV_LFSR_TAPS = 128'h87;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tv_state_e;

    // Table lookup. Tables deeper than four entries are zero-filled.
    function automatic logic [127:0] tv_entry(input int unsigned i);
        case (i)
            0:       return TV_ENTRY0;
            1:       return TV_ENTRY1;
            2:       return TV_ENTRY2;
            3:       return TV_ENTRY3;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/aes_tv_lfsr.sv
// -----------------------------------------------------------------------------
// aes_tv_lfsr
//   DATA_W-bit Galois LFSR (left shift, feedback from the MSB) used as the
//   pseudo-random vector generator of aes_vector_source.
//   Parameters:
//     DATA_W  register width
//     TAPS    feedback mask XORed in when the bit shifted out is 1
//     SEED    value loaded on reset and on every 'load'; 0 becomes 1
//   Ports:
//     clk         in   system clock
//     rst_n       in   asynchronous active-low reset
//     load        in   reload the seed (has priority over advance)
//     advance     in   step the register once
//     next_value  out  value the register takes on the next advance
//     seed_value  out  effective seed (what 'load' writes)
// -----------------------------------------------------------------------------
module aes_tv_lfsr #(
    parameter int                DATA_W = 128,
    parameter logic [DATA_W-1:0] TAPS   = DATA_W'(128'h87),
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] next_value,
    output logic [DATA_W-1:0] seed_value
);

    // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced
    // by 1 to keep the sequence alive.
    localparam logic [DATA_W-1:0] SEED_EFF = (SEED == '0) ? DATA_W'(1) : SEED;

    logic [DATA_W-1:0] value;

    assign seed_value = SEED_EFF;
    assign next_value = {value[DATA_W-2:0], 1'b0} ^ (value[DATA_W-1] ? TAPS : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= SEED_EFF;
        end else if (load) begin
            value <= SEED_EFF;
        end else if (advance) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/aes_vector_source.sv
// -----------------------------------------------------------------------------
// aes_vector_source
//   Programmable burst source of DATA_W-bit test vectors for the AES-128 core.
//   A burst of 'count' beats is launched from IDLE with 'start'; each beat is
//   a fixed table entry, a sequential walk through the table, or the next
//   value of an internal Galois LFSR.
//
//   Stream handshake: a beat transfers on a rising clock edge where
//   out_valid && out_ready. While out_valid is high and out_ready is low,
//   out_data and out_valid hold. out_valid never drops without a transfer
//   except on abort or reset.
//
//   Ports:
//     clk         in   system clock
//     rst_n       in   asynchronous active-low reset
//     start       in   one-cycle burst request, honoured in IDLE only
//     mode        in   0 fixed, 1 sequential, 2 lfsr, 3 behaves as fixed
//     idx         in   fixed entry (mode 0) or first entry (mode 1)
//     count       in   beats in the burst; 0 means the start is ignored
//     abort       in   cancel the running burst (no done pulse)
//     out_data    out  current vector
//     out_valid   out  out_data is valid
//     out_ready   in   downstream accepts out_data
//     busy        out  high while a burst is running
//     done        out  one-cycle pulse after the final beat transfers
//     beats_sent  out  beats transferred in the current/last burst (saturates)
// -----------------------------------------------------------------------------
module aes_vector_source
    import aes_tv_pkg::*;
#(
    parameter int                DATA_W    = 128,
    parameter int                DEPTH     = 4,
    parameter int                CNT_W     = 16,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(TV_LFSR_TAPS),
    parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [CNT_W-1:0]         count,
    input  logic                     abort,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         beats_sent
);

    localparam int IDX_W = $clog2(DEPTH);

    // -------------------------------------------------------------------------
    // Constant vector table, truncated to DATA_W
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] tv_table [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_table
        assign tv_table[g] = DATA_W'(tv_entry(g));
    end

    // -------------------------------------------------------------------------
    // Burst state
    // -------------------------------------------------------------------------
    tv_state_e         state;
    logic [1:0]        mode_q;     // latched, already folded to a legal mode
    logic [IDX_W-1:0]  fixed_idx;  // entry used by MODE_FIXED
    logic [IDX_W-1:0]  ptr;        // entry currently on out_data in MODE_SEQ
    logic [CNT_W-1:0]  remaining;  // beats still to transfer, including current

    // -------------------------------------------------------------------------
    // LFSR
    // -------------------------------------------------------------------------
    logic              lfsr_load;
    logic              lfsr_advance;
    logic [DATA_W-1:0] lfsr_next;
    logic [DATA_W-1:0] lfsr_seed;

    aes_tv_lfsr #(
        .DATA_W (DATA_W),
        .TAPS   (LFSR_TAPS),
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (lfsr_load),
        .advance    (lfsr_advance),
        .next_value (lfsr_next),
        .seed_value (lfsr_seed)
    );

    // -------------------------------------------------------------------------
    // Next-cycle decisions
    // -------------------------------------------------------------------------
    logic              beat;
    logic              last_beat;
    logic              start_ok;
    logic [1:0]        mode_in;
    logic [IDX_W-1:0]  ptr_next;
    logic [DATA_W-1:0] first_vec;
    logic [DATA_W-1:0] next_vec;

    always_comb begin
        // out_valid is only ever high in RUN, so this is the RUN-state transfer.
        beat      = out_valid && out_ready;
        last_beat = beat && (remaining == CNT_W'(1));
        start_ok  = (state == IDLE) && start && (count != '0);

        // The reserved encoding behaves like MODE_FIXED.
        mode_in = ((mode == MODE_SEQ) || (mode == MODE_LFSR)) ? mode : MODE_FIXED;

        // DEPTH is a power of two, so the natural wrap of IDX_W bits gives
        // DEPTH-1 -> 0.
        ptr_next = ptr + 1'b1;

        // Vector presented on the first beat, chosen from the live inputs.
        first_vec = (mode_in == MODE_LFSR) ? lfsr_seed : tv_table[idx];

        // Vector presented after a transfer, chosen from the latched burst.
        case (mode_q)
            MODE_SEQ:  next_vec = tv_table[ptr_next];
            MODE_LFSR: next_vec = lfsr_next;
            default:   next_vec = tv_table[fixed_idx];
        endcase

        lfsr_load    = start_ok;
        lfsr_advance = beat && (mode_q == MODE_LFSR);
    end

    // -------------------------------------------------------------------------
    // Burst FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode_q     <= MODE_FIXED;
            fixed_idx  <= '0;
            ptr        <= '0;
            remaining  <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            beats_sent <= '0;
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    // abort, and start with count == 0, fall through here
                    // without effect.
                    if (start_ok) begin
                        state      <= RUN;
                        mode_q     <= mode_in;
                        fixed_idx  <= idx;
                        ptr        <= idx;
                        remaining  <= count;
                        beats_sent <= '0;
                        out_data   <= first_vec;
                        out_valid  <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                RUN: begin
                    // start/mode/idx/count are deliberately not looked at here.
                    if (beat) begin
                        remaining <= remaining - 1'b1;
                        ptr       <= ptr_next;
                        if (beats_sent != '1) begin
                            beats_sent <= beats_sent + 1'b1;
                        end
                        if (!last_beat) begin
                            out_data <= next_vec;
                        end
                    end

                    // abort wins over completion: a beat transferred in the
                    // abort cycle is still counted above, but done stays low.
                    if (abort) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (last_beat) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
